result_serializer: RTL and testbench
====================================

Name: result_serializer

Overview:
Downstream stage of the 4-bit operator-demo combinational block. On a capture strobe it snapshots that block's nine 4-bit result fields. It then streams them out one nibble per beat over a valid/ready interface to a narrow consumer such as a UART or LED-scan driver. It contains no arithmetic of its own apart from the optional check nibble.

Parameters:
DATA_W, 4, width of each result field and of out_data.
IDX_W, 4, width of out_index; must satisfy 2**IDX_W >= 10.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst  input  1  synchronous, active-high reset.
capture  input  1  snapshot request; honoured only in a cycle where busy=0.
arithmetic  input  DATA_W  field 0.
shift  input  DATA_W  field 1.
relational  input  DATA_W  field 2.
equality  input  DATA_W  field 3.
bitwise  input  DATA_W  field 4.
reduction  input  DATA_W  field 5.
logical  input  DATA_W  field 6.
concatenation  input  DATA_W  field 7.
conditional  input  DATA_W  field 8.
out_valid  output  1  beat available.
out_ready  input  1  consumer accepts beat.
out_data  output  DATA_W  current field value.
out_index  output  IDX_W  index of current field.
out_last  output  1  marks final beat of the frame.
busy  output  1  capture registers hold an unsent frame.
done  output  1  one-cycle pulse after the final beat transfers.

Behaviour:
- Reset (rst=1 at a clk edge) forces state IDLE and clears all outputs: out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, done=0. Capture registers are cleared to 0.
- States: IDLE and SEND.
- IDLE with capture=1: register all nine fields at that edge and go to SEND.
  - Next cycle: busy=1, out_valid=1, out_index=0, out_data=field 0. Latency from capture to first valid is 1 cycle.
- SEND: a beat transfers on an edge where out_valid=1 and out_ready=1.
  - On transfer, out_index increments by 1 and out_data shows the next field.
  - While out_valid=1 and out_ready=0, out_data, out_index and out_last must hold stable.
  - out_valid never drops mid-frame.
- out_last=1 exactly when out_index equals the last beat index (8, or 9 with the optional feature).
- Final transfer: next cycle state=IDLE, out_valid=0, busy=0, done=1 for exactly one cycle. out_index returns to 0.
- capture while busy=1 is ignored; the snapshot does not change mid-frame.
- capture in the done cycle is accepted, because busy=0. The new frame's first valid appears the next cycle, giving back-to-back frames with a one-cycle bubble.
- Input fields changing after capture have no effect on the frame in flight.
- Reset mid-frame aborts the frame immediately: no done pulse and no further beats.
- out_ready held at 1 gives a sustained rate of one beat per cycle.
- Index arithmetic is unsigned IDX_W. Index never exceeds the last beat index, so wrap-around cannot occur.

Optional Feature:
Macro: RESULT_SER_CHECK_EN
- Defined:
  - Capture also stores a check nibble equal to the XOR of all nine fields.
  - The frame gains a tenth beat, index 9, carrying that nibble.
  - out_last moves to index 9 and done follows the tenth transfer.
- Undefined: frame is nine beats, indices 0..8, with no check register.

Decomposition:
- Package result_ser_pkg holds:
  - state enum {IDLE, SEND};
  - NUM_FIELDS=9;
  - named index constants FLD_ARITH..FLD_COND (0..8), plus FLD_CHECK=9.
- No sub-module is needed. The block is a single module with a field mux indexed by out_index.

Test Plan:
- Reset, then drive fields from A=5,B=3,C=1,D=5 (arith=4, shift=1, rel=1, eq=1, bitwise=1, red=1, logical=1, concat=5, cond=5). Pulse capture with out_ready=1 -> 9 consecutive beats with data 4,1,1,1,1,1,1,5,5 and index 0..8. out_last appears only on index 8. done pulses one cycle later.
- Same frame with out_ready toggling 1,0,0,1,... -> each beat held stable while ready=0. Exactly 9 transfers, no duplicates or skips.
- Pulse capture again at beat 3 and change all fields to 0xF -> remaining beats still carry the original values. Second capture ignored.
- capture asserted in the done cycle with all fields=0xA -> new frame starts next cycle with data 0xA at index 0.
- Assert rst at beat 5 -> next cycle out_valid=0, busy=0, done never pulses. A later capture restarts cleanly at index 0.
- RESULT_SER_CHECK_EN defined, first scenario's data -> 10 beats. Beat 9 data=4, out_last on index 9 only.

Source files
------------

// File: rtl/result_ser_pkg.sv
// Shared types and field indices for the result serializer.
// Check beat index is used only when RESULT_SER_CHECK_EN is defined.
package result_ser_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int NUM_FIELDS = 9;

    localparam int FLD_ARITH  = 0;
    localparam int FLD_SHIFT  = 1;
    localparam int FLD_REL    = 2;
    localparam int FLD_EQ     = 3;
    localparam int FLD_BIT    = 4;
    localparam int FLD_RED    = 5;
    localparam int FLD_LOGIC  = 6;
    localparam int FLD_CONCAT = 7;
    localparam int FLD_COND   = 8;
    localparam int FLD_CHECK  = 9;

endpackage

// File: rtl/result_serializer.sv
// Snapshots nine result nibbles and streams them one per valid/ready beat.
// RESULT_SER_CHECK_EN appends a tenth beat holding the XOR of all fields.
module result_serializer
    import result_ser_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [DATA_W-1:0] arithmetic,
    input  logic [DATA_W-1:0] shift,
    input  logic [DATA_W-1:0] relational,
    input  logic [DATA_W-1:0] equality,
    input  logic [DATA_W-1:0] bitwise,
    input  logic [DATA_W-1:0] reduction,
    input  logic [DATA_W-1:0] logical,
    input  logic [DATA_W-1:0] concatenation,
    input  logic [DATA_W-1:0] conditional,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

`ifdef RESULT_SER_CHECK_EN
    localparam int NUM_BEATS = NUM_FIELDS + 1;
`else
    localparam int NUM_BEATS = NUM_FIELDS;
`endif

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

    state_t                             state;
    logic [IDX_W-1:0]                   idx;
    logic                               done_q;
    logic [NUM_BEATS-1:0][DATA_W-1:0]   snap;

`ifdef RESULT_SER_CHECK_EN
    logic [DATA_W-1:0] chk;

    always_comb begin
        chk = arithmetic ^ shift ^ relational ^ equality ^ bitwise
            ^ reduction ^ logical ^ concatenation ^ conditional;
    end
`endif

    wire xfer = (state == SEND) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            done_q <= 1'b0;
            snap   <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        snap[FLD_ARITH]  <= arithmetic;
                        snap[FLD_SHIFT]  <= shift;
                        snap[FLD_REL]    <= relational;
                        snap[FLD_EQ]     <= equality;
                        snap[FLD_BIT]    <= bitwise;
                        snap[FLD_RED]    <= reduction;
                        snap[FLD_LOGIC]  <= logical;
                        snap[FLD_CONCAT] <= concatenation;
                        snap[FLD_COND]   <= conditional;
`ifdef RESULT_SER_CHECK_EN
                        snap[FLD_CHECK]  <= chk;
`endif
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx == LAST_IDX) begin
                            idx    <= '0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data reads zero outside a frame so idle outputs match the reset state.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if ((state == SEND) && (idx == IDX_W'(i))) begin
                out_data = snap[i];
            end
        end
    end

    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_index = idx;
    assign out_last  = (state == SEND) && (idx == LAST_IDX);
    assign done      = done_q;

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: vector table, corner
// sequences and randomized frames against a field-list model.
module tb_result_serializer;

`ifdef RESULT_SER_CHECK_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif

    typedef logic [8:0][3:0] fld_t;

    typedef struct {
        logic [3:0] data;
        logic [3:0] idx;
        logic       last;
    } vec_t;

    logic clk = 0;
    logic rst = 0;
    logic capture = 0;
    logic out_ready = 0;
    logic [3:0] f_ar, f_sh, f_rl, f_eq, f_bw, f_rd, f_lg, f_cc, f_cd;
    logic out_valid, out_last, busy, done;
    logic [3:0] out_data;
    logic [3:0] out_index;

    int tests = 0;
    int fails = 0;

    vec_t tbl[10];

    result_serializer #(.DATA_W(4), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .capture(capture),
        .arithmetic(f_ar), .shift(f_sh), .relational(f_rl),
        .equality(f_eq), .bitwise(f_bw), .reduction(f_rd),
        .logical(f_lg), .concatenation(f_cc), .conditional(f_cd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: a frame is the field list, plus the XOR of all fields when enabled.
    function automatic logic [3:0] mbeat(input fld_t f, input int i);
        logic [3:0] x;
        if (i < 9) return f[i];
        x = 4'h0;
        for (int k = 0; k < 9; k++) x = x ^ f[k];
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_fields(input fld_t f);
        f_ar = f[0]; f_sh = f[1]; f_rl = f[2];
        f_eq = f[3]; f_bw = f[4]; f_rd = f[5];
        f_lg = f[6]; f_cc = f[7]; f_cd = f[8];
    endtask

    task automatic do_capture(input fld_t f);
        put_fields(f);
        capture = 1;
        step();
        capture = 0;
    endtask

    function automatic logic pick_ready(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Streams one frame, checking each beat against the model; optionally
    // re-captures all-F fields at beat disturb_at (must be ignored).
    task automatic drain(input fld_t f, input int mode, input int disturb_at,
                         output int cycles);
        int sent = 0;
        bit held = 0;
        logic [3:0] pd, pi;
        logic pl;
        cycles = 0;
        while (sent < NB && cycles < 300) begin
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            if (held) begin
                chk("hold_data", out_data, pd);
                chk("hold_idx", out_index, pi);
                chk("hold_last", out_last, pl);
            end
            chk("data", out_data, mbeat(f, sent));
            chk("index", out_index, sent);
            chk("last", out_last, sent == NB - 1);
            pd = out_data; pi = out_index; pl = out_last;
            if (disturb_at == sent) begin
                put_fields({9{4'hF}});
                capture = 1;
            end
            out_ready = pick_ready(mode, cycles);
            step();
            capture = 0;
            if (out_ready) begin
                sent++;
                held = 0;
            end else begin
                held = 1;
            end
            cycles++;
        end
        if (cycles >= 300) chk("timeout", 1, 0);
    endtask

    task automatic check_done();
        chk("done_pulse", done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        chk("done_idx", out_index, 0);
    endtask

    fld_t base, fa, rf;
    int cyc;

    initial begin
        base = '0;
        base[0] = 4'd4; base[1] = 4'd1; base[2] = 4'd1;
        base[3] = 4'd1; base[4] = 4'd1; base[5] = 4'd1;
        base[6] = 4'd1; base[7] = 4'd5; base[8] = 4'd5;
        fa = {9{4'hA}};

        tbl[0] = '{4'd4, 4'd0, 1'b0};
        tbl[1] = '{4'd1, 4'd1, 1'b0};
        tbl[2] = '{4'd1, 4'd2, 1'b0};
        tbl[3] = '{4'd1, 4'd3, 1'b0};
        tbl[4] = '{4'd1, 4'd4, 1'b0};
        tbl[5] = '{4'd1, 4'd5, 1'b0};
        tbl[6] = '{4'd1, 4'd6, 1'b0};
        tbl[7] = '{4'd5, 4'd7, 1'b0};
        tbl[8] = '{4'd5, 4'd8, NB == 9};
        tbl[9] = '{4'd4, 4'd9, 1'b1};

        put_fields('0);
        rst = 1;
        step(); step();
        rst = 0;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data", out_data, 0);
        chk("rst_idx", out_index, 0);
        chk("rst_last", out_last, 0);

        // Vector table: full-rate frame from the operator demo values.
        out_ready = 1;
        do_capture(base);
        for (int i = 0; i < NB; i++) begin
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", out_data, tbl[i].data);
            chk("tbl_idx", out_index, tbl[i].idx);
            chk("tbl_last", out_last, tbl[i].last);
            step();
        end
        check_done();
        step();
        chk("done_one_cycle", done, 0);

        // Stalling consumer.
        do_capture(base);
        drain(base, 1, -1, cyc);
        check_done();
        step();

        // Mid-frame capture with new inputs is ignored; then capture in done cycle.
        out_ready = 1;
        do_capture(base);
        drain(base, 0, 3, cyc);
        chk("rate", cyc, NB);
        check_done();
        do_capture(fa);
        chk("b2b_data", out_data, 4'hA);
        drain(fa, 0, -1, cyc);
        check_done();
        step();

        // Reset mid-frame at beat 5.
        do_capture(base);
        out_ready = 1;
        repeat (5) step();
        chk("pre_abort_idx", out_index, 5);
        rst = 1;
        step();
        rst = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_done", done, 0);
            chk("abort_no_beat", out_valid, 0);
            step();
        end
        do_capture(fa);
        drain(fa, 2, -1, cyc);
        check_done();
        step();

        // Randomized frames.
        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 9; k++) rf[k] = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) step();
            do_capture(rf);
            drain(rf, 2, $urandom_range(0, 1) ? int'($urandom_range(0, NB - 1)) : -1, cyc);
            check_done();
            step();
            chk("rand_done_clr", done, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
